// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM side of the multicore memory system.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_SERVE = 1'b1
  } arb_state_t;

  // Width of a CPU index; a single CPU still needs one bit to hold id 0.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for a, b already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority encoder: first set request scanning rr, rr+1, ... mod CPUS.
module rr_picker
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int IW   = idx_w(CPUS)
) (
  input  logic [CPUS-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Rotate so that bit 0 is the CPU at the pointer; doubling handles the wrap.
  logic [2*CPUS-1:0] rot;
  assign rot = {req, req} >> rr;

  // Lowest set bit of the rotated vector, mapped back to a CPU id.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < CPUS; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        idx   = IW'(wrap_add(int'(rr), k, CPUS));
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Multiplexes per-CPU instruction/data requests onto the single RAM port.
// Round-robin across CPUs, data before instruction within a CPU, one
// arbitration cycle (ARB_IDLE) between consecutive transactions.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  output logic                         ramREN,
  output logic                         ramWEN,
  input  logic [WORD_W-1:0]            ramload,
  input  ramstate_t                    ramstate
);

  localparam int IW = idx_w(CPUS);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, rr, rr_nxt, pick_idx;
  logic            is_data, pick_valid;
  logic [CPUS-1:0] req;
  logic            sel_req, complete, abort;

  assign req = iREN | dREN | dWEN;

  rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick (
    .req   (req),
    .rr    (rr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Owner's currently selected request; a drop means the client gave up.
  always_comb begin
    sel_req = 1'b0;
    if (state == ARB_SERVE)
      sel_req = is_data ? (dREN[owner] | dWEN[owner]) : iREN[owner];
  end

  // ERROR/BUSY/FREE all just hold; only ACCESS ends a transaction.
  assign complete = sel_req && (ramstate == ACCESS);
  assign abort    = (state == ARB_SERVE) && !sel_req;
  assign rr_nxt   = (owner == IW'(CPUS-1)) ? '0 : owner + 1'b1;

  // Next-state logic: grant from IDLE, return to IDLE on completion or abort.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:  if (pick_valid)         state_nxt = ARB_SERVE;
      ARB_SERVE: if (complete || abort)  state_nxt = ARB_IDLE;
      default:                           state_nxt = ARB_IDLE;
    endcase
  end

  // State, grant latch and fairness pointer (pointer moves only on completion).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= ARB_IDLE;
      owner   <= '0;
      is_data <= 1'b0;
      rr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && pick_valid) begin
        owner   <= pick_idx;
        is_data <= dREN[pick_idx] | dWEN[pick_idx];
      end
      if (complete) rr <= rr_nxt;
    end
  end

  // RAM port driven live from the owner's request; write beats read.
  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    if (sel_req) begin
      if (is_data) begin
        ramaddr  = daddr[owner];
        ramstore = dstore[owner];
        ramWEN   = dWEN[owner];
        ramREN   = dREN[owner] & ~dWEN[owner];
      end else begin
        ramaddr  = iaddr[owner];
        ramREN   = 1'b1;
      end
    end
  end

  // Per-lane waits follow the request except on that lane's completion cycle.
  for (genvar c = 0; c < CPUS; c++) begin : g_lane
    logic own;
    assign own      = complete && (owner == IW'(c));
    assign iwait[c] = iREN[c] & ~(own & ~is_data);
    assign dwait[c] = (dREN[c] | dWEN[c]) & ~(own & is_data);
    assign iload[c] = ramload;
    assign dload[c] = ramload;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed + randomized bench for ram_arbiter (CPUS=4) against a
// transaction-level reference model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int N = 4;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [N-1:0]        iREN, dREN, dWEN, iwait, dwait;
  logic [N-1:0][31:0]  iaddr, daddr, dstore, iload, dload;
  logic [31:0]         ramaddr, ramstore, ramload;
  logic                ramREN, ramWEN;
  ramstate_t           ramstate;

  int checks = 0;
  int failures = 0;

  // Reference model: whether a transaction is in flight, who owns it,
  // whether it is a data access, and the fairness pointer.
  bit m_serve;
  int m_owner;
  bit m_data;
  int m_rr;

  ram_arbiter #(.CPUS(N), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_serve = 0; m_owner = 0; m_data = 0; m_rr = 0;
  endtask

  task automatic model_eval(output bit sel, output bit done);
    int o;
    o = m_owner;
    sel = m_serve && (m_data ? (dREN[o] || dWEN[o]) : iREN[o]);
    done = sel && (ramstate == ACCESS);
  endtask

  // Compare every output against the model for the current cycle.
  task automatic cyc_pre();
    bit sel, done;
    int o;
    logic [N-1:0] ei, ed;
    #1;
    model_eval(sel, done);
    o = m_owner;
    chk("ramREN", ramREN, sel && (m_data ? (dREN[o] && !dWEN[o]) : 1'b1));
    chk("ramWEN", ramWEN, sel && m_data && dWEN[o]);
    if (!m_serve || sel) begin
      chk("ramaddr", ramaddr, !sel ? 32'h0 : (m_data ? daddr[o] : iaddr[o]));
      chk("ramstore", ramstore, (sel && m_data) ? dstore[o] : 32'h0);
    end
    for (int c = 0; c < N; c++) begin
      ei[c] = iREN[c] && !(done && !m_data && c == o);
      ed[c] = (dREN[c] || dWEN[c]) && !(done && m_data && c == o);
    end
    chk("iwait", iwait, ei);
    chk("dwait", dwait, ed);
    chk("iload", iload, {N{ramload}});
    chk("dload", dload, {N{ramload}});
  endtask

  // Advance the model by one clock, then wait for the DUT edge.
  task automatic cyc_post();
    bit sel, done;
    int c;
    model_eval(sel, done);
    if (!m_serve) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (iREN[c] || dREN[c] || dWEN[c]) begin
          m_serve = 1; m_owner = c; m_data = dREN[c] || dWEN[c];
          break;
        end
      end
    end else if (!sel) begin
      m_serve = 0;
    end else if (done) begin
      m_serve = 0;
      m_rr = (m_owner + 1) % N;
    end
    @(posedge CLK); #3;
  endtask

  task automatic cyc();
    cyc_pre();
    cyc_post();
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    @(posedge CLK); #3;
    nRST = 1'b1;
  endtask

  initial begin
    clear_inputs();
    ramload = 32'h0; ramstate = FREE;
    model_reset();
    nRST = 1'b0;

    // Reset: enables off, waits follow requests.
    iREN = 4'b0101; dWEN = 4'b1000;
    @(posedge CLK); #3;
    cyc_pre();
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iwait", iwait, 4'b0101);
    chk("rst_dwait", dwait, 4'b1000);
    clear_inputs();
    nRST = 1'b1;

    // Zero-wait data read from CPU0.
    dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    cyc_pre();
    chk("t1_idle_ren", ramREN, 1'b0);
    cyc_post();
    cyc_pre();
    chk("t1_ren", ramREN, 1'b1);
    chk("t1_addr", ramaddr, 32'h100);
    chk("t1_dwait", dwait[0], 1'b0);
    chk("t1_dload", dload[0], 32'hDEADBEEF);
    cyc_post();
    dREN[0] = 1'b0;
    cyc();

    // Two instruction streams, BUSY,BUSY,ACCESS: grants alternate every 4 cycles.
    do_reset();
    iREN = 4'b0011; iaddr[0] = 32'hA0; iaddr[1] = 32'hA1;
    for (int k = 0; k < 16; k++) begin
      ramstate = (k % 4 == 3) ? ACCESS : BUSY;
      ramload = $urandom;
      cyc_pre();
      if (k % 4 == 3) chk("t2_grant", iwait[1:0], ((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
      else            chk("t2_hold", iwait[1:0], 2'b11);
      cyc_post();
    end
    iREN = '0;

    // CPU1 write + instruction together: write first, then instruction.
    iREN[1] = 1'b1; iaddr[1] = 32'h200; dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'h5;
    ramstate = ACCESS;
    cyc();
    cyc_pre();
    chk("t3_wen", ramWEN, 1'b1);
    chk("t3_ren", ramREN, 1'b0);
    chk("t3_store", ramstore, 32'h5);
    chk("t3_addr", ramaddr, 32'h40);
    chk("t3_dwait", dwait[1], 1'b0);
    chk("t3_iwait", iwait[1], 1'b1);
    cyc_post();
    dWEN[1] = 1'b0;
    cyc();
    cyc_pre();
    chk("t3_iren", ramREN, 1'b1);
    chk("t3_iaddr", ramaddr, 32'h200);
    chk("t3_iwait_done", iwait[1], 1'b0);
    cyc_post();
    iREN = '0;

    // Move pointer to 3 via a CPU2 access, then CPU0 and CPU2 compete: wrap to CPU0.
    dREN[2] = 1'b1; daddr[2] = 32'h300;
    cyc(); cyc();
    dREN[2] = 1'b0;
    iREN = 4'b0101; iaddr[0] = 32'hB0; iaddr[2] = 32'hB2;
    cyc();
    cyc_pre();
    chk("t4_wrap", iwait, 4'b0100);
    cyc_post();
    cyc();
    cyc_pre();
    chk("t4_rr1", iwait, 4'b0001);
    cyc_post();
    iREN = '0;

    // Abort during BUSY: enables drop, pointer stays at 3.
    dREN[0] = 1'b1; daddr[0] = 32'h500; ramstate = BUSY;
    cyc();
    cyc_pre();
    chk("t5_busy_ren", ramREN, 1'b1);
    cyc_post();
    dREN[0] = 1'b0;
    cyc_pre();
    chk("t5_abort_ren", ramREN, 1'b0);
    chk("t5_abort_wen", ramWEN, 1'b0);
    cyc_post();
    iREN = 4'b1010; iaddr[3] = 32'h333; iaddr[1] = 32'h111;
    cyc();
    cyc_pre();
    chk("t5_rr_kept", ramaddr, 32'h333);
    nRST = 1'b0;
    #1;
    chk("t5_rst_ren", ramREN, 1'b0);
    chk("t5_rst_addr", ramaddr, 32'h0);
    chk("t5_rst_iwait", iwait, 4'b1010);
    model_reset();
    @(posedge CLK); #3;
    nRST = 1'b1;
    cyc();
    cyc_pre();
    chk("t5_rr_zero", ramaddr, 32'h111);
    cyc_post();
    clear_inputs();
    cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(3) == 0) begin
          iREN[c] = $urandom_range(1);
          dREN[c] = $urandom_range(1);
          dWEN[c] = ($urandom_range(2) == 0);
        end
        iaddr[c] = $urandom; daddr[c] = $urandom; dstore[c] = $urandom;
      end
      ramstate = ramstate_t'($urandom_range(3));
      ramload = $urandom;
      cyc();
    end

    clear_inputs();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
